// File: rtl/vram_slot_arbiter.sv
// -----------------------------------------------------------------------------
// vram_slot_arbiter
//
// Purpose:
//   This block shares one VRAM port among NUM_CH requesters and the display
//   fetch path. An access slot opens at each CLK21M edge where
//   DOTSTATE == 2'b10, and at most one access is decided in that slot.
//     - If DRAW_RESERVE is set, the display always takes the slot.
//     - Otherwise the lowest-index pending channel wins.
//   Each channel uses a toggle handshake:
//     - A channel raises a request by making CH_REQ[i] differ from CH_ACK[i].
//     - The arbiter answers by toggling CH_ACK[i].
//     - For a write, the ack toggles on the grant edge.
//     - For a read, the ack toggles RD_LAT cycles after the grant, on the
//       same edge that loads CH_RDATA.
//
// Handshake contract (per channel i):
//   - Request:  CH_REQ[i] != CH_ACK[i]. While the request is outstanding, the
//     requester holds CH_WE[i], CH_ADDR[i] and CH_WDATA[i] stable.
//   - Complete: CH_ACK[i] toggles. The requester may toggle CH_REQ[i] again
//     on the following cycle.
//
// Optional feature (macro VRAM_ARB_AGING_EN):
//   Each channel has a saturating age counter. A channel whose age has reached
//   AGE_MAX beats every channel still below AGE_MAX. Ties between aged
//   channels go to the lowest index.
//
// Ports:
//   CLK21M        system clock
//   RESET_N       synchronous reset, active low
//   DOTSTATE      dot phase; 2'b10 marks an access slot
//   DRAW_RESERVE  display owns the current slot
//   DRAW_ADDR     display fetch address
//   CH_REQ        per-channel request toggles
//   CH_WE         per-channel write enable (1 = write), sampled at grant
//   CH_ADDR       packed channel addresses, channel i at [i*ADDR_W +: ADDR_W]
//   CH_WDATA      packed channel write data, channel i at [i*DATA_W +: DATA_W]
//   CH_ACK        per-channel ack toggles
//   CH_RDATA      read data, valid when the ack for a read toggles
//   PRAMDBI       VRAM read data
//   IRAMADR       VRAM address
//   PRAMDBO       VRAM write data
//   PRAMWE_N      VRAM write strobe, active low, one cycle per write
//   GRANT_OH      one-hot owner of the last slot; zero for display or idle
// -----------------------------------------------------------------------------
module vram_slot_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 2,
  parameter int AGE_MAX = 15
) (
  input  logic                       CLK21M,
  input  logic                       RESET_N,
  input  logic [1:0]                 DOTSTATE,
  input  logic                       DRAW_RESERVE,
  input  logic [ADDR_W-1:0]          DRAW_ADDR,
  input  logic [NUM_CH-1:0]          CH_REQ,
  input  logic [NUM_CH-1:0]          CH_WE,
  input  logic [NUM_CH*ADDR_W-1:0]   CH_ADDR,
  input  logic [NUM_CH*DATA_W-1:0]   CH_WDATA,
  output logic [NUM_CH-1:0]          CH_ACK,
  output logic [DATA_W-1:0]          CH_RDATA,
  input  logic [DATA_W-1:0]          PRAMDBI,
  output logic [ADDR_W-1:0]          IRAMADR,
  output logic [DATA_W-1:0]          PRAMDBO,
  output logic                       PRAMWE_N,
  output logic [NUM_CH-1:0]          GRANT_OH
);

  localparam int         IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [1:0] SLOT_PHASE = 2'b10;

  logic [ADDR_W-1:0]              iramadr_q, iramadr_d;
  logic [DATA_W-1:0]              pramdbo_q, pramdbo_d;
  logic                           pramwe_n_q, pramwe_n_d;
  logic [NUM_CH-1:0]              grant_oh_q, grant_oh_d;
  logic [NUM_CH-1:0]              ch_ack_q, ch_ack_d;
  logic [DATA_W-1:0]              ch_rdata_q, ch_rdata_d;

  // Read pipe: stage k holds a read granted k+1 edges ago. A read leaves the
  // pipe on the edge RD_LAT cycles after its grant. At most one grant happens
  // per edge, so a depth of RD_LAT is enough.
  logic [RD_LAT-1:0]              pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0][IDX_W-1:0]   pipe_ch_q, pipe_ch_d;

  logic                           access_slot;
  logic [NUM_CH-1:0]              in_flight;
  logic [NUM_CH-1:0]              pending;
  logic                           win_vld;
  logic [IDX_W-1:0]               win_idx;

  assign access_slot = (DOTSTATE == SLOT_PHASE);

  // A channel with a read still in the pipe is not eligible again until its
  // ack toggles, even though its req and ack still differ.
  always_comb begin
    in_flight = '0;
    for (int k = 0; k < RD_LAT; k++) begin
      if (pipe_vld_q[k]) begin
        in_flight[pipe_ch_q[k]] = 1'b1;
      end
    end
    pending = (CH_REQ ^ ch_ack_q) & ~in_flight;
  end

`ifdef VRAM_ARB_AGING_EN
  localparam int               AGE_W   = (AGE_MAX > 0) ? $clog2(AGE_MAX + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);

  logic [NUM_CH-1:0][AGE_W-1:0] age_q, age_d;
  logic [NUM_CH-1:0]            aged;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      aged[i] = pending[i] && (age_q[i] >= AGE_LIM);
    end
  end
`endif

  // Fixed priority. The loop runs downward so that the lowest index is the
  // last one assigned and therefore wins.
  always_comb begin
    win_vld = |pending;
    win_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_idx = IDX_W'(i);
      end
    end
`ifdef VRAM_ARB_AGING_EN
    if (|aged) begin
      win_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (aged[i]) begin
          win_idx = IDX_W'(i);
        end
      end
    end
`endif
  end

`ifdef VRAM_ARB_AGING_EN
  // Reserved slots do not count toward aging. Only contested slots do.
  always_comb begin
    age_d = age_q;
    if (access_slot && !DRAW_RESERVE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (win_vld && (win_idx == IDX_W'(i))) begin
          age_d[i] = '0;
        end else if (pending[i] && (age_q[i] != {AGE_W{1'b1}})) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK21M) begin
    if (!RESET_N) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`endif

  always_comb begin
    iramadr_d  = iramadr_q;
    pramdbo_d  = pramdbo_q;
    pramwe_n_d = 1'b1;            // each write strobe lasts exactly one cycle
    grant_oh_d = grant_oh_q;
    ch_ack_d   = ch_ack_q;
    ch_rdata_d = ch_rdata_q;

    pipe_vld_d[0] = 1'b0;
    pipe_ch_d[0]  = '0;
    for (int k = 1; k < RD_LAT; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_ch_d[k]  = pipe_ch_q[k-1];
    end

    // Read completion. A completing channel is always in flight, so it can
    // never be the winner of this same edge; the two ack toggles never
    // touch the same bit.
    if (pipe_vld_q[RD_LAT-1]) begin
      ch_rdata_d                      = PRAMDBI;
      ch_ack_d[pipe_ch_q[RD_LAT-1]]   = ~ch_ack_q[pipe_ch_q[RD_LAT-1]];
    end

    if (access_slot) begin
      if (DRAW_RESERVE) begin
        iramadr_d  = DRAW_ADDR;
        grant_oh_d = '0;
      end else if (win_vld) begin
        grant_oh_d = NUM_CH'(1) << win_idx;
        iramadr_d  = CH_ADDR[int'(win_idx) * ADDR_W +: ADDR_W];
        if (CH_WE[win_idx]) begin
          pramdbo_d          = CH_WDATA[int'(win_idx) * DATA_W +: DATA_W];
          pramwe_n_d         = 1'b0;
          ch_ack_d[win_idx]  = ~ch_ack_q[win_idx];
        end else begin
          pipe_vld_d[0] = 1'b1;
          pipe_ch_d[0]  = win_idx;
        end
      end else begin
        grant_oh_d = '0;
      end
    end
  end

  always_ff @(posedge CLK21M) begin
    if (!RESET_N) begin
      iramadr_q  <= '1;
      pramdbo_q  <= '0;
      pramwe_n_q <= 1'b1;
      grant_oh_q <= '0;
      ch_ack_q   <= '0;
      ch_rdata_q <= '0;
      pipe_vld_q <= '0;
      pipe_ch_q  <= '0;
    end else begin
      iramadr_q  <= iramadr_d;
      pramdbo_q  <= pramdbo_d;
      pramwe_n_q <= pramwe_n_d;
      grant_oh_q <= grant_oh_d;
      ch_ack_q   <= ch_ack_d;
      ch_rdata_q <= ch_rdata_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_ch_q  <= pipe_ch_d;
    end
  end

  assign IRAMADR  = iramadr_q;
  assign PRAMDBO  = pramdbo_q;
  assign PRAMWE_N = pramwe_n_q;
  assign GRANT_OH = grant_oh_q;
  assign CH_ACK   = ch_ack_q;
  assign CH_RDATA = ch_rdata_q;

endmodule
